bus_arbiter_rr: RTL and testbench

- Parametrised N-master bus arbiter for the serial system bus. Successor to the fixed 2-master arbiter.
- Adds selectable round-robin or fixed-priority arbitration and a maximum-tenure timeout with safe preemption.
- Grants the bus only when all slaves report ready.
- Drives the one-hot grants and the binary master-select that steers the interconnect's write-side muxes.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_arbiter_rr_if.sv | 23 ++
 rtl/rr_priority_picker.sv | 36 +++
 rtl/bus_arbiter_rr.sv | 99 +++++++++
 tb/tb_bus_arbiter_rr.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus arbiter and its helpers.
package bus_pkg;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  localparam logic IDLE_ENC  = 1'b0;
  localparam logic GRANT_ENC = 1'b1;

  typedef enum logic {
    IDLE  = IDLE_ENC,
    GRANT = GRANT_ENC
  } arb_state_t;

  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the bus masters, the slaves' ready lines and the arbiter.
interface bus_arbiter_rr_if
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3
);
  localparam int MSEL_WIDTH = idx_width(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_SLAVES-1:0]  sready;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [MSEL_WIDTH-1:0]  msel;
  logic                   bus_busy;
  logic                   timeout;

  // master: the requesting side; slave: the arbiter serving those requests.
  modport master (output breq, output sready,
                  input bgrant, input msel, input bus_busy, input timeout);
  modport slave  (input breq, input sready,
                  output bgrant, output msel, output bus_busy, output timeout);

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational winner selection: round-robin after a last pointer, or lowest index first.
module rr_priority_picker
  import bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  input  logic               i_mode,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  logic w_found;

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    w_found = 1'b0;
    if (i_mode == ARB_FIXED) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (i_req[i]) o_idx = IDX_W'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        automatic int j = (int'(i_last) + k) % NUM_REQ;
        if (!w_found && i_req[j]) begin
          o_idx   = IDX_W'(j);
          w_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter with round-robin/fixed priority, all-slaves-ready gating
// and a maximum-tenure timeout that only preempts when the bus is quiet.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int NUM_SLAVES     = 3,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             rstn,
  bus_arbiter_rr_if.slave bus
);

  localparam int MSEL_WIDTH = idx_width(NUM_MASTERS);
  localparam int TEN_WIDTH  = idx_width(TIMEOUT_CYCLES);
  localparam bit TMO_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic [TEN_WIDTH-1:0]  TEN_LAST =
    TEN_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [MSEL_WIDTH-1:0] LAST_RST  = MSEL_WIDTH'(NUM_MASTERS - 1);
  localparam logic                  PICK_MODE = (ARB_MODE == 0) ? ARB_RR : ARB_FIXED;

  arb_state_t             r_state;
  logic [NUM_MASTERS-1:0] r_bgrant;
  logic [MSEL_WIDTH-1:0]  r_msel;
  logic [MSEL_WIDTH-1:0]  r_last;
  logic                   r_busy;
  logic                   r_timeout;
  logic [TEN_WIDTH-1:0]   r_tenure;

  logic                   w_all_ready;
  logic                   w_pick_valid;
  logic [MSEL_WIDTH-1:0]  w_pick_idx;
  logic [NUM_MASTERS-1:0] w_pick_onehot;
  logic                   w_owner_req;
  logic                   w_tmo_hit;

  rr_priority_picker #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (MSEL_WIDTH)
  ) u_picker (
    .i_req   (bus.breq),
    .i_last  (r_last),
    .i_mode  (PICK_MODE),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_all_ready   = &bus.sready;
  assign w_pick_onehot = NUM_MASTERS'(1) << w_pick_idx;
  assign w_owner_req   = |(bus.breq & r_bgrant);
  assign w_tmo_hit     = TMO_EN && (r_tenure == TEN_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_bgrant  <= '0;
      r_msel    <= '0;
      r_last    <= LAST_RST;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_tenure  <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid && w_all_ready) begin
            r_bgrant <= w_pick_onehot;
            r_msel   <= w_pick_idx;
            r_busy   <= 1'b1;
            r_tenure <= '0;
            r_state  <= GRANT;
          end
        end
        GRANT: begin
          // Release always lands in IDLE, which enforces the turnaround cycle.
          if (!w_owner_req || (w_tmo_hit && w_all_ready)) begin
            r_bgrant  <= '0;
            r_busy    <= 1'b0;
            r_last    <= r_msel;
            r_tenure  <= '0;
            r_timeout <= w_owner_req;
            r_state   <= IDLE;
          end else if (r_tenure != TEN_LAST) begin
            r_tenure <= r_tenure + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bgrant   = r_bgrant;
  assign bus.msel     = r_msel;
  assign bus.bus_busy = r_busy;
  assign bus.timeout  = r_timeout;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed self-checking bench: RR and fixed-priority arbiters, TIMEOUT_CYCLES=8.
module tb_bus_arbiter_rr;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr_if #(.NUM_MASTERS(4), .NUM_SLAVES(3)) if_rr ();
  bus_arbiter_rr_if #(.NUM_MASTERS(4), .NUM_SLAVES(3)) if_fx ();

  bus_arbiter_rr #(
    .NUM_MASTERS(4), .NUM_SLAVES(3), .ARB_MODE(0), .TIMEOUT_CYCLES(8)
  ) u_rr (.clk(clk), .rstn(rstn), .bus(if_rr));

  bus_arbiter_rr #(
    .NUM_MASTERS(4), .NUM_SLAVES(3), .ARB_MODE(1), .TIMEOUT_CYCLES(8)
  ) u_fx (.clk(clk), .rstn(rstn), .bus(if_fx));

  typedef struct packed {
    logic [3:0] breq;
    logic [2:0] sready;
    logic [3:0] bgrant;
    logic [1:0] msel;
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic [3:0] breq, input logic [2:0] sready,
                              input logic [3:0] bgrant, input logic [1:0] msel,
                              input logic busy, input logic tmo);
    vec_t v;
    v.breq = breq; v.sready = sready; v.bgrant = bgrant;
    v.msel = msel; v.busy = busy; v.tmo = tmo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_rr(input string tag, input logic [3:0] bg, input logic [1:0] ms,
                        input logic busy, input logic tmo);
    chk({tag, ".bgrant"},  32'(if_rr.bgrant),   32'(bg));
    chk({tag, ".msel"},    32'(if_rr.msel),     32'(ms));
    chk({tag, ".busy"},    32'(if_rr.bus_busy), 32'(busy));
    chk({tag, ".timeout"}, 32'(if_rr.timeout),  32'(tmo));
  endtask

  task automatic chk_fx(input string tag, input logic [3:0] bg, input logic [1:0] ms,
                        input logic busy, input logic tmo);
    chk({tag, ".bgrant"},  32'(if_fx.bgrant),   32'(bg));
    chk({tag, ".msel"},    32'(if_fx.msel),     32'(ms));
    chk({tag, ".busy"},    32'(if_fx.bus_busy), 32'(busy));
    chk({tag, ".timeout"}, 32'(if_fx.timeout),  32'(tmo));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    if_rr.breq = '0; if_rr.sready = 3'b111;
    if_fx.breq = '0; if_fx.sready = 3'b111;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Grant invariants: one-hot-or-zero and granted master requested on the prior edge.
  logic [3:0] prev_rr, prev_fx;
  always @(posedge clk) begin
    prev_rr <= if_rr.breq;
    prev_fx <= if_fx.breq;
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("inv_onehot_rr", 32'($onehot0(if_rr.bgrant)), 32'd1);
      chk("inv_onehot_fx", 32'($onehot0(if_fx.bgrant)), 32'd1);
      chk("inv_req_rr", 32'(if_rr.bgrant & ~prev_rr), 32'd0);
      chk("inv_req_fx", 32'(if_fx.bgrant & ~prev_fx), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord [5];
    ord = '{0, 1, 2, 3, 0};

    if_rr.breq = '0; if_rr.sready = 3'b111;
    if_fx.breq = '0; if_fx.sready = 3'b111;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_rr("reset_rr", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk_fx("reset_fx", 4'b0000, 2'd0, 1'b0, 1'b0);
    rstn = 1'b1;

    //               breq     sready  bgrant   msel busy tmo
    vecs[0]  = mk(4'b0000, 3'b111, 4'b0000, 2'd0, 1'b0, 1'b0);
    vecs[1]  = mk(4'b0001, 3'b111, 4'b0001, 2'd0, 1'b1, 1'b0);
    vecs[2]  = mk(4'b0001, 3'b111, 4'b0001, 2'd0, 1'b1, 1'b0);
    vecs[3]  = mk(4'b0000, 3'b111, 4'b0000, 2'd0, 1'b0, 1'b0);
    vecs[4]  = mk(4'b0011, 3'b111, 4'b0010, 2'd1, 1'b1, 1'b0);
    vecs[5]  = mk(4'b0011, 3'b111, 4'b0010, 2'd1, 1'b1, 1'b0);
    vecs[6]  = mk(4'b0001, 3'b111, 4'b0000, 2'd1, 1'b0, 1'b0);
    vecs[7]  = mk(4'b0001, 3'b111, 4'b0001, 2'd0, 1'b1, 1'b0);
    vecs[8]  = mk(4'b0000, 3'b111, 4'b0000, 2'd0, 1'b0, 1'b0);
    vecs[9]  = mk(4'b0100, 3'b011, 4'b0000, 2'd0, 1'b0, 1'b0);
    vecs[10] = mk(4'b0100, 3'b011, 4'b0000, 2'd0, 1'b0, 1'b0);
    vecs[11] = mk(4'b0100, 3'b111, 4'b0100, 2'd2, 1'b1, 1'b0);
    vecs[12] = mk(4'b0100, 3'b011, 4'b0100, 2'd2, 1'b1, 1'b0);
    vecs[13] = mk(4'b1100, 3'b111, 4'b0100, 2'd2, 1'b1, 1'b0);
    vecs[14] = mk(4'b1000, 3'b111, 4'b0000, 2'd2, 1'b0, 1'b0);
    vecs[15] = mk(4'b1000, 3'b111, 4'b1000, 2'd3, 1'b1, 1'b0);
    vecs[16] = mk(4'b0000, 3'b111, 4'b0000, 2'd3, 1'b0, 1'b0);
    vecs[17] = mk(4'b1001, 3'b111, 4'b0001, 2'd0, 1'b1, 1'b0);
    vecs[18] = mk(4'b0000, 3'b111, 4'b0000, 2'd0, 1'b0, 1'b0);
    vecs[19] = mk(4'b0010, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0);
    vecs[20] = mk(4'b0000, 3'b111, 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      if_rr.breq   = vecs[i].breq;
      if_rr.sready = vecs[i].sready;
      tick();
      chk_rr($sformatf("vec%0d", i), vecs[i].bgrant, vecs[i].msel, vecs[i].busy, vecs[i].tmo);
    end

    // Async reset mid-grant clears outputs without a clock edge; pointer returns to 3.
    if_rr.breq = 4'b0010;
    tick();
    chk_rr("pre_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk_rr("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    if_rr.breq = 4'b1001;
    tick();
    chk_rr("ptr_after_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
    if_rr.breq = 4'b0000;
    tick();
    chk_rr("rel_after_rst", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Round-robin rotation with all masters requesting.
    do_reset();
    if_rr.breq = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk_rr($sformatf("rot%0d_grant", n), 4'(1 << ord[n]), 2'(ord[n]), 1'b1, 1'b0);
      repeat (2) begin
        tick();
        chk_rr($sformatf("rot%0d_hold", n), 4'(1 << ord[n]), 2'(ord[n]), 1'b1, 1'b0);
      end
      if_rr.breq[ord[n]] = 1'b0;
      tick();
      chk_rr($sformatf("rot%0d_gap", n), 4'b0000, 2'(ord[n]), 1'b0, 1'b0);
      if_rr.breq = 4'b1111;
    end
    if_rr.breq = 4'b0000;
    tick();

    // Timeout after 8 cycles, then deferred timeout while a slave is busy.
    do_reset();
    if_rr.breq = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_rr($sformatf("tmo_m0_c%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk_rr("tmo_m0_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_rr("tmo_m1_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk_rr($sformatf("tmo_m1_c%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    if_rr.sready = 3'b101;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_rr($sformatf("defer_c%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    if_rr.sready = 3'b111;
    tick();
    chk_rr("defer_pulse", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    chk_rr("defer_next", 4'b0001, 2'd0, 1'b1, 1'b0);
    if_rr.breq = 4'b0000;
    tick();

    // Fixed priority: master 1 always beats master 3.
    do_reset();
    if_fx.breq = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk_fx($sformatf("fix%0d_grant", n), 4'b0010, 2'd1, 1'b1, 1'b0);
      tick();
      chk_fx($sformatf("fix%0d_hold", n), 4'b0010, 2'd1, 1'b1, 1'b0);
      if_fx.breq = 4'b1000;
      tick();
      chk_fx($sformatf("fix%0d_gap", n), 4'b0000, 2'd1, 1'b0, 1'b0);
      if_fx.breq = 4'b1010;
    end
    tick();
    chk_fx("fix_final", 4'b0010, 2'd1, 1'b1, 1'b0);
    if_fx.breq = 4'b1000;
    tick();
    chk_fx("fix_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    chk_fx("fix_m3", 4'b1000, 2'd3, 1'b1, 1'b0);
    if_fx.breq = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
